// File: rtl/sm_accumulator.sv
// Sign-magnitude accumulator: sums LEN operands (or fewer on flush) per result,
// with optional saturation on overflow and valid/ready handshakes on both sides.
module sm_accumulator #(
    parameter int N   = 16,
    parameter int LEN = 4,
    parameter int SAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         in_sub,
    input  logic         in_flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_ovf
);
    localparam int MW = N - 1;
    localparam int CW = $clog2(LEN + 1);

    typedef enum logic {ACC, HOLD} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ovf_q, ovf_d;
    logic [N-1:0]   out_data_q, out_data_d;
    logic           out_ovf_q, out_ovf_d;

    logic [MW-1:0]  op_mag, acc_mag, res_mag;
    logic           op_sgn, acc_sgn, res_sgn, add_ovf;
    logic [N-1:0]   sum, acc_next;

    // Sign-magnitude add of the effective operand into the accumulator
    always_comb begin
        op_mag  = in_data[MW-1:0];
        op_sgn  = (op_mag != '0) & (in_data[N-1] ^ in_sub);
        acc_mag = acc_q[MW-1:0];
        acc_sgn = acc_q[N-1];
        sum     = {1'b0, acc_mag} + {1'b0, op_mag};
        add_ovf = 1'b0;
        res_sgn = acc_sgn;
        res_mag = sum[MW-1:0];
        if (acc_sgn == op_sgn) begin
            add_ovf = sum[MW];
            if (sum[MW] && SAT != 0) res_mag = '1;
        end else if (acc_mag >= op_mag) begin
            res_mag = acc_mag - op_mag;
        end else begin
            res_mag = op_mag - acc_mag;
            res_sgn = op_sgn;
        end
        // never produce negative zero
        if (res_mag == '0) res_sgn = 1'b0;
        acc_next = {res_sgn, res_mag};
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
        case (state_q)
            ACC: begin
                if (in_valid) begin
                    acc_d = acc_next;
                    ovf_d = ovf_q | add_ovf;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(LEN - 1) || in_flush) begin
                        state_d    = HOLD;
                        out_data_d = acc_next;
                        out_ovf_d  = ovf_q | add_ovf;
                    end
                end else if (in_flush) begin
                    state_d    = HOLD;
                    out_data_d = acc_q;
                    out_ovf_d  = ovf_q;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACC;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ACC;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == HOLD);
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
endmodule
